// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 1250;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer, resets to the idle-high line level
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and ACK handshake
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RXD,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    input  logic                 ACK,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN,
    output logic                 BUSY
);

    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CW-1:0]    BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;
    logic                 prev_q;
    logic [1:0]           warm_q;
    logic                 rxs;
    logic                 fall;

    sync2 u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (RXD),
        .q   (rxs)
    );

    // The synchronizer's reset value looks like an idle line; only trust edges
    // once prev_q holds a genuinely sampled level, so a line low at release is ignored.
    assign fall = (warm_q == 2'd3) && prev_q && !rxs;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
            prev_q  <= 1'b1;
            warm_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
            prev_q  <= rxs;
            warm_q  <= (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A completing byte always wins over ACK; OVERRUN only when the old byte was never taken.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (done_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q & ~ACK;
        end else if (ACK) begin
            valid_d = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    assign DATA      = data_q;
    assign VALID     = valid_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        int         due;
        logic       ovr;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RXD = 1'b1;
    logic       ACK = 1'b0;
    logic [7:0] DATA;
    logic       VALID;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    exp_t exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RXD       (RXD),
        .DATA      (DATA),
        .VALID     (VALID),
        .ACK       (ACK),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (FRAME_ERR === 1'b1) fe_cnt = fe_cnt + 1;
        if (OVERRUN === 1'b1)   ov_cnt = ov_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Drives one frame starting now (just after a rising edge). A byte with a high
    // stop bit is pushed to the scoreboard and popped when its VALID edge is due:
    // start mid-sample + 8 bits + stop mid-sample + one register stage = 156 cycles.
    task automatic send_byte(input logic [7:0] b, input logic stop_val,
                             input int stop_periods, input logic exp_ovr,
                             input logic chk_lat);
        exp_t e;
        int   t0;
        t0 = cyc;
        if (stop_val) begin
            e.data = b;
            e.due  = t0 + 10 * CPB - 4;
            e.ovr  = exp_ovr;
            exp_q.push_back(e);
        end
        RXD = 1'b0;
        repeat (CPB) @(posedge CLK);
        #1;
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (CPB) @(posedge CLK);
            #1;
        end
        RXD = stop_val;
        for (int k = 0; k < CPB * stop_periods; k++) begin
            @(negedge CLK);
            if (chk_lat && stop_val && cyc == t0 + 10 * CPB - 5) begin
                checks++;
                if (VALID !== 1'b0) begin
                    errors++;
                    $display("FAIL valid_early: VALID=%b one cycle before due, need 0", VALID);
                end
            end
            if (exp_q.size() > 0 && cyc == exp_q[0].due) begin
                e = exp_q.pop_front();
                checks++;
                if (DATA !== e.data || VALID !== 1'b1 || OVERRUN !== e.ovr || FRAME_ERR !== 1'b0) begin
                    errors++;
                    $display("FAIL rx_byte: got DATA=%h VALID=%b OVERRUN=%b FRAME_ERR=%b, need DATA=%h VALID=1 OVERRUN=%b FRAME_ERR=0",
                             DATA, VALID, OVERRUN, FRAME_ERR, e.data, e.ovr);
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse_ack();
        ACK = 1'b1;
        @(posedge CLK);
        #1;
        ACK = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({DATA, VALID, FRAME_ERR, OVERRUN, BUSY} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: DATA=%h VALID=%b FE=%b OVR=%b BUSY=%b, need all 0",
                     DATA, VALID, FRAME_ERR, OVERRUN, BUSY);
        end
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        checks++;
        if (BUSY !== 1'b0 || VALID !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: BUSY=%b VALID=%b, need 0 0", BUSY, VALID);
        end
    endtask

    task automatic test_clean_byte();
        int fe0, ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_byte(8'hA5, 1'b1, 1, 1'b0, 1'b1);
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL clean_pulses: FE pulses=%0d OVR pulses=%0d, need 0 0", fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_back_to_back();
        int ov0;
        pulse_ack();
        ov0 = ov_cnt;
        send_byte(8'h3C, 1'b1, 1, 1'b0, 1'b1);
        send_byte(8'hC3, 1'b1, 1, 1'b1, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (ov_cnt - ov0 != 1) begin
            errors++;
            $display("FAIL overrun_count: got %0d pulses, need 1", ov_cnt - ov0);
        end
        pulse_ack();
        checks++;
        if (VALID !== 1'b0) begin
            errors++;
            $display("FAIL ack_clears: VALID=%b, need 0", VALID);
        end
        pulse_ack();
        checks++;
        if (VALID !== 1'b0 || DATA !== 8'hC3) begin
            errors++;
            $display("FAIL ack_idle: VALID=%b DATA=%h, need 0 c3", VALID, DATA);
        end
    endtask

    task automatic test_false_start();
        RXD = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RXD = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL false_start_busy: BUSY=%b, need 1", BUSY);
        end
        repeat (7) @(posedge CLK);
        #1;
        checks++;
        if (BUSY !== 1'b0 || VALID !== 1'b0) begin
            errors++;
            $display("FAIL false_start_idle: BUSY=%b VALID=%b, need 0 0", BUSY, VALID);
        end
        repeat (10) @(posedge CLK);
        #1;
    endtask

    task automatic test_frame_error();
        int fe0, ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_byte(8'h55, 1'b0, 3, 1'b0, 1'b0);
        checks++;
        if (BUSY !== 1'b1 || fe_cnt - fe0 != 1 || VALID !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_break: BUSY=%b FE pulses=%0d VALID=%b, need 1 1 0",
                     BUSY, fe_cnt - fe0, VALID);
        end
        RXD = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        checks++;
        if (BUSY !== 1'b0 || VALID !== 1'b0 || ov_cnt != ov0 || DATA !== 8'hC3) begin
            errors++;
            $display("FAIL frame_err_recover: BUSY=%b VALID=%b OVR pulses=%0d DATA=%h, need 0 0 0 c3",
                     BUSY, VALID, ov_cnt - ov0, DATA);
        end
        repeat (10) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        RXD = 1'b0;
        repeat (CPB) @(posedge CLK);
        #1;
        RXD = 1'b1;
        repeat (4 * CPB + 5) @(posedge CLK);
        #3;
        RST = 1'b1;
        #2;
        checks++;
        if ({DATA, VALID, FRAME_ERR, OVERRUN, BUSY} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_frame: DATA=%h VALID=%b FE=%b OVR=%b BUSY=%b, need all 0",
                     DATA, VALID, FRAME_ERR, OVERRUN, BUSY);
        end
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        send_byte(8'h0F, 1'b1, 1, 1'b0, 1'b1);
    endtask

    task automatic test_ack_same_edge();
        int ov0;
        ov0 = ov_cnt;
        fork
            send_byte(8'h81, 1'b1, 1, 1'b0, 1'b0);
            begin
                repeat (10 * CPB - 5) @(posedge CLK);
                #1;
                ACK = 1'b1;
                @(posedge CLK);
                #1;
                ACK = 1'b0;
            end
        join
        checks++;
        if (ov_cnt != ov0 || VALID !== 1'b1 || DATA !== 8'h81) begin
            errors++;
            $display("FAIL ack_same_edge: OVR pulses=%0d VALID=%b DATA=%h, need 0 1 81",
                     ov_cnt - ov0, VALID, DATA);
        end
    endtask

    task automatic test_low_at_release();
        RXD = 1'b0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3 * CPB) @(posedge CLK);
        #1;
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL low_at_release: BUSY=%b, need 0", BUSY);
        end
        RXD = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
    endtask

    initial begin
        test_reset();
        test_clean_byte();
        test_back_to_back();
        test_false_start();
        test_frame_error();
        test_reset_mid_frame();
        test_ack_same_edge();
        test_low_at_release();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bytes still expected, need 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1250: CLK cycles per serial bit (48 MHz / 1250 = 38400 baud).
REQ-002 SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port RXD, input, 1: serial line, asynchronous to CLK, idle high; frame is 8N1, LSB first.
REQ-005 SHALL have port DATA, output, 8: last received byte.
REQ-006 SHALL have port VALID, output, 1: DATA holds an unconsumed byte.
REQ-007 SHALL have port ACK, input, 1: consumer takes DATA; clears VALID.
REQ-008 SHALL have port FRAME_ERR, output, 1: one-cycle pulse when a stop bit samples low.
REQ-009 SHALL have port OVERRUN, output, 1: one-cycle pulse when a byte completes while VALID is already high.
REQ-010 SHALL have port BUSY, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL pass RXD through a two-flop synchronizer; all later logic uses the synchronized value rxs, which lags RXD by 2 cycles.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP and BREAK.
REQ-013 IDLE: on rxs high-to-low, clear the bit counter and go to START.
REQ-014 START: after CLKS_PER_BIT/2 cycles, sample rxs; if low, go to DATA; if high, return to IDLE (false start) with no output.
REQ-015 DATA: sample rxs every CLKS_PER_BIT cycles after the start mid-point and shift it into an 8-bit register, LSB first.
REQ-016 DATA: after the 8th sample, go to STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, sample rxs.
REQ-018 STOP, sample high: on the next edge, load DATA, set VALID, and go to IDLE.
REQ-019 STOP, sample low: pulse FRAME_ERR, leave DATA and VALID unchanged, and go to BREAK.
REQ-020 BREAK: stay until rxs is high, then go to IDLE.
REQ-021 Latency: VALID SHALL rise exactly one cycle after the stop-bit mid-sample edge.
REQ-022 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide, reset to 0 on every sample, and never wrap mid-bit.
REQ-023 VALID SHALL stay high until the edge on which ACK is sampled high; ACK while VALID is low has no effect.
REQ-024 Completion with VALID high: overwrite DATA, keep VALID high, pulse OVERRUN.
REQ-025 Completion and ACK on the same edge: load the new DATA, keep VALID high, no OVERRUN.
REQ-026 A new start edge SHALL be accepted in the cycle after returning to IDLE, allowing back-to-back frames.

Reset
REQ-027 RST high SHALL asynchronously force: FSM to IDLE; counters to 0; DATA to 8'h00; VALID, FRAME_ERR, OVERRUN and BUSY to 0; synchronizer flops to 1.
REQ-028 Reset mid-frame SHALL discard the partial byte.
REQ-029 After RST deasserts, the block SHALL wait for a fresh high-to-low edge on rxs before starting; a line held low at reset release is not a start.

Structure
REQ-030 A shared package uart_pkg SHALL hold the CLKS_PER_BIT default, the FSM state encoding, and the frame constants (DATA_BITS=8, STOP_BITS=1), for reuse by uart_tx.
REQ-031 The two-flop synchronizer SHALL be a separate sub-module, sync2 (input d, output q, reset value 1).
REQ-032 All outputs SHALL be registered.

Verification (bench uses CLKS_PER_BIT=16)
REQ-033 Send 8'hA5 with a clean stop -> VALID rises one cycle after the stop mid-sample, DATA=8'hA5, no FRAME_ERR or OVERRUN.
REQ-034 Send 8'h3C, then 8'hC3 back-to-back with no ACK -> second completion gives DATA=8'hC3, VALID high, one OVERRUN pulse.
REQ-035 Send 8'h55 with the stop bit held low for 3 bit times -> one FRAME_ERR pulse, VALID stays 0, BUSY high until the line returns high.
REQ-036 Pulse RXD low for 4 cycles -> no VALID, BUSY returns low by the start mid-point.
REQ-037 Assert RST during data bit 4 of 8'hFF -> all outputs are reset values; a following 8'h0F is received correctly.
REQ-038 Assert ACK on the same edge as completion of 8'h81 -> DATA=8'h81, VALID high, no OVERRUN.
